// File: rtl/perceptron_trainer.sv
// ---------------------------------------------------------------------------
// perceptron_trainer
//
// On-chip learning engine for the digit-classifier perceptron. A labelled
// 7-bit feature sample is scored against every class, one class per cycle.
// The engine reports the arg-max class. In train mode, a wrong prediction
// triggers the perceptron update rule on the weight memory.
//
// Flow: IDLE -> SCORE (NUM_CLASSES cycles) -> UPDATE (1) -> DONE -> IDLE
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      sample handshake (features, label, train_en)
//   features[6:0]            binary inputs x0..x6 ([6:4] edges, [3:0] curves)
//   label[3:0], train_en     target class, apply update on mistake
//   out_valid / out_ready    result handshake (pred, mistake)
//   miss_count               number of training updates applied (saturating)
//   wr_en, wr_class, wr_idx, wr_data
//                            direct weight write, honoured in IDLE only
//   rd_class, rd_idx, rd_weight
//                            combinational weight read-back
//
// Optional build macro PERCEPTRON_TRAINER_SAT_EN:
//   defined   -> training updates clamp weights to the signed range
//   undefined -> training updates wrap modulo 2^WEIGHT_W
//   Direct writes are never clamped.
// ---------------------------------------------------------------------------
module perceptron_trainer #(
    parameter int NUM_CLASSES = 10,
    parameter int WEIGHT_W    = 4,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 features,
    input  logic [3:0]                 label,
    input  logic                       train_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 pred,
    output logic                       mistake,
    output logic [CNT_W-1:0]           miss_count,
    input  logic                       wr_en,
    input  logic [3:0]                 wr_class,
    input  logic [2:0]                 wr_idx,
    input  logic signed [WEIGHT_W-1:0] wr_data,
    input  logic [3:0]                 rd_class,
    input  logic [2:0]                 rd_idx,
    output logic signed [WEIGHT_W-1:0] rd_weight
);

    // Score width: bias plus seven terms can never exceed WEIGHT_W+3 bits.
    localparam int SW = WEIGHT_W + 3;
    localparam logic [4:0] NC5  = 5'(NUM_CLASSES);
    localparam logic [3:0] LAST = 4'(NUM_CLASSES - 1);

`ifdef PERCEPTRON_TRAINER_SAT_EN
    localparam logic signed [WEIGHT_W:0] W_MAX = (WEIGHT_W+1)'((1 <<< (WEIGHT_W-1)) - 1);
    localparam logic signed [WEIGHT_W:0] W_MIN = (WEIGHT_W+1)'(-(1 <<< (WEIGHT_W-1)));
`endif

    typedef enum logic [1:0] {IDLE, SCORE, UPDATE, DONE} state_t;

    // One training step on a single weight. x gates the step, up selects
    // the direction. The sum is formed one bit wider so the overflow can be
    // detected for clamping, or simply dropped for wrapping.
    function automatic logic signed [WEIGHT_W-1:0] step_weight(
        input logic signed [WEIGHT_W-1:0] w,
        input logic                       up,
        input logic                       x
    );
        logic signed [WEIGHT_W:0] sum;
        sum = {w[WEIGHT_W-1], w};
        if (x) begin
            if (up) sum = sum + {{WEIGHT_W{1'b0}}, 1'b1};
            else    sum = sum - {{WEIGHT_W{1'b0}}, 1'b1};
        end
`ifdef PERCEPTRON_TRAINER_SAT_EN
        if (sum > W_MAX) return W_MAX[WEIGHT_W-1:0];
        if (sum < W_MIN) return W_MIN[WEIGHT_W-1:0];
`endif
        return sum[WEIGHT_W-1:0];
    endfunction

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [6:0]                 feat_q, feat_d;
    logic [3:0]                 label_q, label_d;
    logic                       train_q, train_d;
    logic [3:0]                 best_q, best_d;
    logic signed [SW-1:0]       best_s_q, best_s_d;
    logic [3:0]                 pred_q, pred_d;
    logic                       mistake_q, mistake_d;
    logic                       out_valid_q, out_valid_d;
    logic [CNT_W-1:0]           miss_q, miss_d;
    logic signed [WEIGHT_W-1:0] w_q [NUM_CLASSES][8];
    logic signed [WEIGHT_W-1:0] w_d [NUM_CLASSES][8];

    logic signed [SW-1:0]       score;
    logic [7:0]                 xv;
    logic                       label_bad;
    logic                       is_mistake;

    // Index 7 is the bias, whose input is always 1.
    assign xv         = {1'b1, feat_q};
    assign label_bad  = ({1'b0, label_q} >= NC5);
    assign is_mistake = label_bad | (best_q != label_q);

    // Score of the class currently addressed by cnt_q.
    always_comb begin
        score = SW'(w_q[cnt_q][7]);
        for (int i = 0; i < 7; i++) begin
            if (feat_q[i]) score = score + SW'(w_q[cnt_q][i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        feat_d      = feat_q;
        label_d     = label_q;
        train_d     = train_q;
        best_d      = best_q;
        best_s_d    = best_s_q;
        pred_d      = pred_q;
        mistake_d   = mistake_q;
        out_valid_d = out_valid_q;
        miss_d      = miss_q;
        w_d         = w_q;

        case (state_q)
            // IDLE: direct writes and sample acceptance; both may share one edge.
            IDLE: begin
                if (wr_en && ({1'b0, wr_class} < NC5)) begin
                    w_d[wr_class][wr_idx] = wr_data;
                end
                if (in_valid) begin
                    feat_d   = features;
                    label_d  = label;
                    train_d  = train_en;
                    cnt_d    = '0;
                    best_d   = '0;
                    best_s_d = '0;
                    state_d  = SCORE;
                end
            end
            // SCORE: strict compare so ties keep the lowest class index;
            // class 0 always seeds the running best.
            SCORE: begin
                if ((cnt_q == 4'd0) || (score > best_s_q)) begin
                    best_d   = cnt_q;
                    best_s_d = score;
                end
                if (cnt_q == LAST) state_d = UPDATE;
                else               cnt_d   = cnt_q + 4'd1;
            end
            // UPDATE: reward the label row, penalise the predicted row.
            UPDATE: begin
                pred_d      = best_q;
                mistake_d   = is_mistake;
                out_valid_d = 1'b1;
                state_d     = DONE;
                if (train_q && is_mistake && !label_bad) begin
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        for (int i = 0; i < 8; i++) begin
                            if (4'(c) == label_q)
                                w_d[c][i] = step_weight(w_q[c][i], 1'b1, xv[i]);
                            else if (4'(c) == best_q)
                                w_d[c][i] = step_weight(w_q[c][i], 1'b0, xv[i]);
                        end
                    end
                    if (miss_q != '1) miss_d = miss_q + 1'b1;
                end
            end
            // DONE: hold the result until the consumer takes it.
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            feat_q      <= '0;
            label_q     <= '0;
            train_q     <= 1'b0;
            best_q      <= '0;
            best_s_q    <= '0;
            pred_q      <= '0;
            mistake_q   <= 1'b0;
            out_valid_q <= 1'b0;
            miss_q      <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                for (int i = 0; i < 8; i++) begin
                    w_q[c][i] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            feat_q      <= feat_d;
            label_q     <= label_d;
            train_q     <= train_d;
            best_q      <= best_d;
            best_s_q    <= best_s_d;
            pred_q      <= pred_d;
            mistake_q   <= mistake_d;
            out_valid_q <= out_valid_d;
            miss_q      <= miss_d;
            w_q         <= w_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign pred       = pred_q;
    assign mistake    = mistake_q;
    assign miss_count = miss_q;
    assign rd_weight  = ({1'b0, rd_class} < NC5) ? w_q[rd_class][rd_idx] : '0;

endmodule

// File: tb/tb_perceptron_trainer.sv
module tb_perceptron_trainer;

    localparam int NC = 10;
    localparam int WW = 4;
    localparam int CW = 16;
    localparam int WMAX = (1 << (WW - 1)) - 1;
    localparam int WMIN = -(1 << (WW - 1));

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [6:0]           features;
    logic [3:0]           label;
    logic                 train_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           pred;
    logic                 mistake;
    logic [CW-1:0]        miss_count;
    logic                 wr_en;
    logic [3:0]           wr_class;
    logic [2:0]           wr_idx;
    logic signed [WW-1:0] wr_data;
    logic [3:0]           rd_class;
    logic [2:0]           rd_idx;
    logic signed [WW-1:0] rd_weight;

    perceptron_trainer #(.NUM_CLASSES(NC), .WEIGHT_W(WW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .features(features), .label(label), .train_en(train_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .pred(pred), .mistake(mistake), .miss_count(miss_count),
        .wr_en(wr_en), .wr_class(wr_class), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_class(rd_class), .rd_idx(rd_idx), .rd_weight(rd_weight)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: weights, mistake counter and pending results.
    int mw [NC][8];
    int mmiss;
    typedef struct {
        logic [3:0] pred;
        logic       mistake;
        int         miss;
    } exp_t;
    exp_t exp_q[$];

    function automatic int fix_w(input int v);
`ifdef PERCEPTRON_TRAINER_SAT_EN
        if (v > WMAX) return WMAX;
        if (v < WMIN) return WMIN;
        return v;
`else
        if (v > WMAX) return v - (1 << WW);
        if (v < WMIN) return v + (1 << WW);
        return v;
`endif
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < 8; i++) mw[c][i] = 0;
        mmiss = 0;
        exp_q.delete();
    endfunction

    function automatic void model_run(input logic [6:0] f, input logic [3:0] l,
                                      input logic t, output exp_t e);
        int best = 0;
        int bs = 0;
        int s;
        int xi;
        logic mis;
        for (int c = 0; c < NC; c++) begin
            s = mw[c][7];
            for (int i = 0; i < 7; i++) if (f[i]) s += mw[c][i];
            if (c == 0 || s > bs) begin
                bs = s;
                best = c;
            end
        end
        mis = (int'(l) >= NC) || (best != int'(l));
        if (t && mis && int'(l) < NC) begin
            for (int i = 0; i < 8; i++) begin
                xi = (i == 7) ? 1 : int'(f[i]);
                mw[l][i]    = fix_w(mw[l][i] + xi);
                mw[best][i] = fix_w(mw[best][i] - xi);
            end
            if (mmiss < (1 << CW) - 1) mmiss++;
        end
        e.pred    = 4'(best);
        e.mistake = mis;
        e.miss    = mmiss;
    endfunction

    task automatic read_w(input int c, input int i, output logic signed [WW-1:0] v);
        rd_class = 4'(c);
        rd_idx   = 3'(i);
        #1;
        v = rd_weight;
    endtask

    task automatic check_weights(input string nm);
        logic signed [WW-1:0] v;
        logic signed [WW-1:0] want;
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < 8; i++) begin
                read_w(c, i, v);
                want = WW'(mw[c][i]);
                total++;
                if (v !== want) begin
                    $display("FAIL %s W[%0d][%0d] got=%0d want=%0d", nm, c, i, v, want);
                    bad++;
                end
            end
        end
    endtask

    task automatic write_w(input int c, input int i, input int v);
        @(negedge clk);
        wr_en = 1'b1; wr_class = 4'(c); wr_idx = 3'(i); wr_data = WW'(v);
        @(negedge clk);
        wr_en = 1'b0;
        if (c < NC) mw[c][i] = v;
    endtask

    task automatic drive_sample(input logic [6:0] f, input logic [3:0] l, input logic t);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL accept_ready in_ready=%0b want=1", in_ready);
            bad++;
        end
        features = f; label = l; train_en = t; in_valid = 1'b1;
        model_run(f, l, t, e);
        exp_q.push_back(e);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid === 1'b1) break;
        end
        total++;
        if (out_valid !== 1'b1) begin
            $display("FAIL out_valid_timeout got=%0b want=1", out_valid);
            bad++;
        end
    endtask

    task automatic check_result(input string nm, output exp_t e);
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s_queue size=0 want>0", nm);
            bad++;
            e.pred = 'x; e.mistake = 'x; e.miss = -1;
            return;
        end
        e = exp_q.pop_front();
        if (pred !== e.pred) begin
            $display("FAIL %s_pred got=%0d want=%0d", nm, pred, e.pred);
            bad++;
        end
        total++;
        if (mistake !== e.mistake) begin
            $display("FAIL %s_mistake got=%0b want=%0b", nm, mistake, e.mistake);
            bad++;
        end
        total++;
        if (int'(miss_count) != e.miss) begin
            $display("FAIL %s_miss got=%0d want=%0d", nm, miss_count, e.miss);
            bad++;
        end
    endtask

    task automatic release_out(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL %s_release out_valid=%0b in_ready=%0b want 0/1", nm, out_valid, in_ready);
            bad++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic signed [WW-1:0] v;
        do_reset();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || pred !== 4'd0 ||
            mistake !== 1'b0 || miss_count !== '0) begin
            $display("FAIL reset_outputs in_ready=%0b out_valid=%0b pred=%0d mistake=%0b miss=%0d want 1/0/0/0/0",
                     in_ready, out_valid, pred, mistake, miss_count);
            bad++;
        end
        read_w(12, 0, v);
        total++;
        if (v !== '0) begin
            $display("FAIL reset_rd_oob got=%0d want=0", v);
            bad++;
        end
        check_weights("reset_weights");
    endtask

    task automatic test_first_sample();
        int lat;
        exp_t e;
        drive_sample(7'h7F, 4'd0, 1'b1);
        wait_out(lat);
        total++;
        if (lat != NC + 2) begin
            $display("FAIL latency got=%0d want=%0d", lat, NC + 2);
            bad++;
        end
        check_result("first", e);
        total++;
        if (pred !== 4'd0 || mistake !== 1'b0 || miss_count !== '0) begin
            $display("FAIL first_const pred=%0d mistake=%0b miss=%0d want 0/0/0", pred, mistake, miss_count);
            bad++;
        end
        release_out("first");
    endtask

    task automatic test_train_correction();
        int lat;
        exp_t e;
        logic signed [WW-1:0] v;
        do_reset();
        drive_sample(7'h05, 4'd3, 1'b1);
        wait_out(lat);
        check_result("train", e);
        total++;
        if (pred !== 4'd0 || mistake !== 1'b1 || miss_count !== 16'd1) begin
            $display("FAIL train_const pred=%0d mistake=%0b miss=%0d want 0/1/1", pred, mistake, miss_count);
            bad++;
        end
        release_out("train");
        read_w(3, 2, v);
        total++;
        if (v !== 4'sd1) begin
            $display("FAIL train_w32 got=%0d want=1", v);
            bad++;
        end
        read_w(0, 7, v);
        total++;
        if (v !== -4'sd1) begin
            $display("FAIL train_w07 got=%0d want=-1", v);
            bad++;
        end
        check_weights("train_weights");
        drive_sample(7'h05, 4'd3, 1'b0);
        wait_out(lat);
        check_result("retest", e);
        total++;
        if (pred !== 4'd3 || mistake !== 1'b0 || miss_count !== 16'd1) begin
            $display("FAIL retest_const pred=%0d mistake=%0b miss=%0d want 3/0/1", pred, mistake, miss_count);
            bad++;
        end
        release_out("retest");
    endtask

    task automatic test_saturation();
        int lat;
        exp_t e;
        logic signed [WW-1:0] v;
        do_reset();
        write_w(0, 0, 7);
        write_w(0, 7, 7);
        write_w(1, 0, 7);
        write_w(1, 7, 7);
        drive_sample(7'h01, 4'd1, 1'b1);
        wait_out(lat);
        check_result("sat", e);
        total++;
        if (pred !== 4'd0 || mistake !== 1'b1) begin
            $display("FAIL sat_const pred=%0d mistake=%0b want 0/1", pred, mistake);
            bad++;
        end
        release_out("sat");
        read_w(1, 0, v);
        total++;
`ifdef PERCEPTRON_TRAINER_SAT_EN
        if (v !== 4'sd7) begin
            $display("FAIL sat_w10 got=%0d want=7", v);
            bad++;
        end
`else
        if (v !== -4'sd8) begin
            $display("FAIL wrap_w10 got=%0d want=-8", v);
            bad++;
        end
`endif
        read_w(0, 7, v);
        total++;
        if (v !== 4'sd6) begin
            $display("FAIL sat_w07 got=%0d want=6", v);
            bad++;
        end
        check_weights("sat_weights");
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        drive_sample(7'h12, 4'd7, 1'b1);
        wait_out(lat);
        check_result("bp", e);
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; features = 7'h7F; label = 4'd2; train_en = 1'b1;
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || pred !== e.pred || mistake !== e.mistake || in_ready !== 1'b0) begin
                $display("FAIL bp_hold cyc=%0d out_valid=%0b pred=%0d mistake=%0b in_ready=%0b want 1/%0d/%0b/0",
                         k, out_valid, pred, mistake, in_ready, e.pred, e.mistake);
                bad++;
            end
        end
        in_valid = 1'b0;
        release_out("bp");
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || int'(miss_count) != mmiss) begin
            $display("FAIL bp_no_accept in_ready=%0b miss=%0d want 1/%0d", in_ready, miss_count, mmiss);
            bad++;
        end
        check_weights("bp_weights");
    endtask

    task automatic test_bad_label();
        int lat;
        exp_t e;
        int miss_before;
        miss_before = mmiss;
        drive_sample(7'h2A, 4'd12, 1'b1);
        wait_out(lat);
        check_result("badlbl", e);
        total++;
        if (mistake !== 1'b1 || int'(miss_count) != miss_before) begin
            $display("FAIL badlbl_const mistake=%0b miss=%0d want 1/%0d", mistake, miss_count, miss_before);
            bad++;
        end
        release_out("badlbl");
        check_weights("badlbl_weights");
    endtask

    task automatic test_reset_mid();
        int lat;
        int old_w;
        exp_t e;
        logic signed [WW-1:0] v;
        old_w = mw[2][3];
        drive_sample(7'h7F, 4'd5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
        wr_en = 1'b1; wr_class = 4'd2; wr_idx = 3'd3; wr_data = 4'sd5;
        @(negedge clk);
        wr_en = 1'b0;
        read_w(2, 3, v);
        total++;
        if (v !== WW'(old_w)) begin
            $display("FAIL score_write got=%0d want=%0d", v, old_w);
            bad++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || miss_count !== '0) begin
            $display("FAIL midrst in_ready=%0b out_valid=%0b miss=%0d want 1/0/0", in_ready, out_valid, miss_count);
            bad++;
        end
        model_reset();
        check_weights("midrst_weights");
        @(negedge clk);
        rst = 1'b0;
        drive_sample(7'h7F, 4'd0, 1'b1);
        wait_out(lat);
        check_result("after_rst", e);
        release_out("after_rst");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; features = '0; label = '0; train_en = 1'b0;
        out_ready = 1'b0; wr_en = 1'b0; wr_class = '0; wr_idx = '0; wr_data = '0;
        rd_class = '0; rd_idx = '0;
        model_reset();
        test_reset();
        test_first_sample();
        test_train_correction();
        test_saturation();
        test_backpressure();
        test_bad_label();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
